main_memory_ctrl: RTL and testbench

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl_pkg.sv | 19 +
 rtl/main_memory_ctrl_mem_line_array.sv | 26 ++
 rtl/main_memory_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_main_memory_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_memory_ctrl_pkg.sv
// Shared widths, default latency and FSM encoding for the main memory controller.
package main_memory_ctrl_pkg;

    localparam int LINE_W      = 128;
    localparam int ADDR_W      = 20;
    localparam int LATENCY_DEF = 5;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:4], 4'h0};
    endfunction

endpackage

// File: rtl/main_memory_ctrl_mem_line_array.sv
// Line storage: one asynchronous read port, one synchronous write port, no reset.
module mem_line_array #(
    parameter int LINE_W    = 128,
    parameter int MEM_LINES = 4096,
    parameter int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_r [MEM_LINES];

    // Write port; contents survive controller reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/main_memory_ctrl.sv
// Main memory controller: arbitrates I-cache fills and D-cache fills/write-backs
// with a fixed response latency over a single line array.
module main_memory_ctrl
    import main_memory_ctrl_pkg::*;
#(
    parameter int LATENCY   = LATENCY_DEF,
    parameter int MEM_LINES = 4096
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              ic_rqst_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              dc_rqst_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_we_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              ic_ready_o,
    output logic              dc_ready_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(MEM_LINES);
    // RESPOND overlaps the first cycle of the next service, so its grant counts one less.
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_NEXT  = CNT_W'(LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ic_pend_r, dc_pend_r, dc_we_pend_r;
    logic [ADDR_W-1:0] ic_addr_pend_r, dc_addr_pend_r;
    logic [LINE_W-1:0] dc_wdata_pend_r;
    logic              gnt_dc_r, last_dc_r, svc_we_r;
    logic [ADDR_W-1:0] svc_addr_r;
    logic [LINE_W-1:0] svc_wdata_r;
    logic              ic_ready_r, dc_ready_r, busy_r;
    logic [LINE_W-1:0] mem_data_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic              in_svc_s, ic_new_s, dc_new_s, ic_cand_s, dc_cand_s;
    logic              grant_s, pick_dc_s, done_s, mem_we_s;
    logic [CNT_W-1:0]  cnt_load_s;
    logic [LINE_W-1:0] rd_data_s;
    logic [IDX_W-1:0]  svc_idx_s;

    // Request acceptance, grant candidates and round-robin choice.
    always_comb begin
        in_svc_s   = (state_r != ST_IDLE);
        ic_new_s   = ic_rqst_i && !ic_pend_r && !(in_svc_s && !gnt_dc_r);
        dc_new_s   = dc_rqst_i && !dc_pend_r && !(in_svc_s && gnt_dc_r);
        ic_cand_s  = 1'b0;
        dc_cand_s  = 1'b0;
        cnt_load_s = CNT_FIRST;
        case (state_r)
            ST_IDLE: begin
                ic_cand_s  = ic_pend_r || ic_new_s;
                dc_cand_s  = dc_pend_r || dc_new_s;
                cnt_load_s = CNT_FIRST;
            end
            ST_RESPOND: begin
                ic_cand_s  = ic_pend_r;
                dc_cand_s  = dc_pend_r;
                cnt_load_s = CNT_NEXT;
            end
            default: begin
                ic_cand_s  = 1'b0;
                dc_cand_s  = 1'b0;
                cnt_load_s = CNT_FIRST;
            end
        endcase
        grant_s = ic_cand_s || dc_cand_s;
        // Priority pointer only matters, and only moves, when both compete.
        if (ic_cand_s && dc_cand_s) begin
            pick_dc_s = !last_dc_r;
        end else begin
            pick_dc_s = dc_cand_s;
        end
        done_s   = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);
        mem_we_s = done_s && svc_we_r;
    end

    assign svc_idx_s = svc_addr_r[4 +: IDX_W];

    mem_line_array #(
        .LINE_W    (LINE_W),
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_s),
        .waddr_i (svc_idx_s),
        .wdata_i (svc_wdata_r),
        .raddr_i (svc_idx_s),
        .rdata_o (rd_data_s)
    );

    // Controller FSM with pending slots, service registers and registered outputs.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            ic_pend_r       <= 1'b0;
            dc_pend_r       <= 1'b0;
            dc_we_pend_r    <= 1'b0;
            ic_addr_pend_r  <= '0;
            dc_addr_pend_r  <= '0;
            dc_wdata_pend_r <= '0;
            gnt_dc_r        <= 1'b0;
            last_dc_r       <= 1'b0;
            svc_we_r        <= 1'b0;
            svc_addr_r      <= '0;
            svc_wdata_r     <= '0;
            ic_ready_r      <= 1'b0;
            dc_ready_r      <= 1'b0;
            busy_r          <= 1'b0;
            mem_data_r      <= '0;
            mem_addr_r      <= '0;
        end else begin
            if (ic_new_s) begin
                ic_pend_r      <= 1'b1;
                ic_addr_pend_r <= ic_addr_i;
            end
            if (dc_new_s) begin
                dc_pend_r       <= 1'b1;
                dc_addr_pend_r  <= dc_addr_i;
                dc_we_pend_r    <= dc_we_i;
                dc_wdata_pend_r <= dc_wdata_i;
            end
            case (state_r)
                ST_IDLE: busy_r <= 1'b0;
                ST_BUSY: begin
                    if (done_s) begin
                        state_r    <= ST_RESPOND;
                        mem_data_r <= svc_we_r ? svc_wdata_r : rd_data_s;
                        mem_addr_r <= line_align(svc_addr_r);
                        ic_ready_r <= !gnt_dc_r;
                        dc_ready_r <= gnt_dc_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESPOND: begin
                    ic_ready_r <= 1'b0;
                    dc_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            // A grant overrides the IDLE/RESPOND defaults above and consumes the slot.
            if (grant_s) begin
                state_r  <= ST_BUSY;
                busy_r   <= 1'b1;
                cnt_r    <= cnt_load_s;
                gnt_dc_r <= pick_dc_s;
                if (ic_cand_s && dc_cand_s) begin
                    last_dc_r <= pick_dc_s;
                end
                if (pick_dc_s) begin
                    dc_pend_r <= 1'b0;
                    if (dc_pend_r) begin
                        svc_addr_r  <= dc_addr_pend_r;
                        svc_we_r    <= dc_we_pend_r;
                        svc_wdata_r <= dc_wdata_pend_r;
                    end else begin
                        svc_addr_r  <= dc_addr_i;
                        svc_we_r    <= dc_we_i;
                        svc_wdata_r <= dc_wdata_i;
                    end
                end else begin
                    ic_pend_r <= 1'b0;
                    svc_we_r  <= 1'b0;
                    if (ic_pend_r) begin
                        svc_addr_r <= ic_addr_pend_r;
                    end else begin
                        svc_addr_r <= ic_addr_i;
                    end
                end
            end
        end
    end

    assign mem_data_o = mem_data_r;
    assign mem_addr_o = mem_addr_r;
    assign ic_ready_o = ic_ready_r;
    assign dc_ready_o = dc_ready_r;
    assign busy_o     = busy_r;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed self-checking bench for main_memory_ctrl (LATENCY = 5).
module tb_main_memory_ctrl;

    localparam int NREC = 40;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b1;
    logic         ic_rqst_i = 1'b0;
    logic [19:0]  ic_addr_i = 20'h0;
    logic         dc_rqst_i = 1'b0;
    logic [19:0]  dc_addr_i = 20'h0;
    logic         dc_we_i = 1'b0;
    logic [127:0] dc_wdata_i = 128'h0;
    logic [127:0] mem_data_o;
    logic [19:0]  mem_addr_o;
    logic         ic_ready_o, dc_ready_o, busy_o;

    int checks = 0;
    int failures = 0;

    logic         rec_ic   [1:NREC];
    logic         rec_dc   [1:NREC];
    logic         rec_busy [1:NREC];
    logic [127:0] rec_data [1:NREC];
    logic [19:0]  rec_addr [1:NREC];

    logic [127:0] pat_a5, pat_11, pat_22, pat_dead;

    main_memory_ctrl #(.LATENCY(5), .MEM_LINES(4096)) dut (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .ic_rqst_i  (ic_rqst_i),
        .ic_addr_i  (ic_addr_i),
        .dc_rqst_i  (dc_rqst_i),
        .dc_addr_i  (dc_addr_i),
        .dc_we_i    (dc_we_i),
        .dc_wdata_i (dc_wdata_i),
        .mem_data_o (mem_data_o),
        .mem_addr_o (mem_addr_o),
        .ic_ready_o (ic_ready_o),
        .dc_ready_o (dc_ready_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one request pulse so it is sampled at the next rising edge (edge E).
    task automatic pulse(input logic ic, input logic [19:0] ia, input logic dc,
                         input logic [19:0] da, input logic we, input logic [127:0] wd);
        ic_rqst_i = ic; ic_addr_i = ia;
        dc_rqst_i = dc; dc_addr_i = da; dc_we_i = we; dc_wdata_i = wd;
        @(posedge clk_i); #1;
        ic_rqst_i = 1'b0; dc_rqst_i = 1'b0; dc_we_i = 1'b0;
    endtask

    // Record outputs 1 ns after edges E+1 .. E+n.
    task automatic observe(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk_i); #1;
            rec_ic[k] = ic_ready_o; rec_dc[k] = dc_ready_o; rec_busy[k] = busy_o;
            rec_data[k] = mem_data_o; rec_addr[k] = mem_addr_o;
        end
    endtask

    function automatic int first_hit(input bit sel_dc, input int n);
        for (int k = 1; k <= n; k++) begin
            if (sel_dc ? rec_dc[k] : rec_ic[k]) return k;
        end
        return 0;
    endfunction

    function automatic int hit_count(input bit sel_dc, input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) begin
            if (sel_dc ? rec_dc[k] : rec_ic[k]) c++;
        end
        return c;
    endfunction

    task automatic test_reset();
        rsn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({ic_ready_o, dc_ready_o, busy_o} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {ic_ready_o, dc_ready_o, busy_o});
        end
        checks++;
        if (mem_data_o !== 128'h0 || mem_addr_o !== 20'h0) begin
            failures++; $display("FAIL reset_outputs: data=%h addr=%h expected zero", mem_data_o, mem_addr_o);
        end
        rsn_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    // Write a line through the D-cache port and check the acknowledge timing.
    task automatic write_line(input logic [19:0] a, input logic [127:0] d);
        pulse(1'b0, 20'h0, 1'b1, a, 1'b1, d);
        observe(6);
        checks++;
        if (first_hit(1'b1, 6) !== 5 || hit_count(1'b1, 6) !== 1) begin
            failures++; $display("FAIL write_ack %h: first=%0d count=%0d expected 5/1", a, first_hit(1'b1, 6), hit_count(1'b1, 6));
        end
        checks++;
        if (rec_data[5] !== d || rec_addr[5] !== {a[19:4], 4'h0}) begin
            failures++; $display("FAIL write_echo %h: data=%h addr=%h expected %h", a, rec_data[5], rec_addr[5], d);
        end
    endtask

    task automatic test_single_fill();
        write_line(20'h00120, pat_a5);
        pulse(1'b1, 20'h00124, 1'b0, 20'h0, 1'b0, 128'h0);
        observe(8);
        checks++;
        if (first_hit(1'b0, 8) !== 5 || hit_count(1'b0, 8) !== 1 || hit_count(1'b1, 8) !== 0) begin
            failures++; $display("FAIL fill_ready: first=%0d count=%0d dc=%0d expected 5/1/0", first_hit(1'b0, 8), hit_count(1'b0, 8), hit_count(1'b1, 8));
        end
        checks++;
        if (rec_addr[5] !== 20'h00120 || rec_data[5] !== pat_a5) begin
            failures++; $display("FAIL fill_data: addr=%h data=%h expected 00120/a5..", rec_addr[5], rec_data[5]);
        end
        checks++;
        if ({rec_busy[1], rec_busy[4], rec_busy[5], rec_busy[6]} !== 4'b1110) begin
            failures++; $display("FAIL fill_busy: got %b expected 1110", {rec_busy[1], rec_busy[4], rec_busy[5], rec_busy[6]});
        end
        checks++;
        if (rec_data[8] !== pat_a5 || rec_addr[8] !== 20'h00120) begin
            failures++; $display("FAIL fill_hold: data=%h addr=%h expected held response", rec_data[8], rec_addr[8]);
        end
    endtask

    task automatic test_write_read();
        write_line(20'h00300, pat_11);
        pulse(1'b1, 20'h00308, 1'b0, 20'h0, 1'b0, 128'h0);
        observe(6);
        checks++;
        if (first_hit(1'b0, 6) !== 5 || rec_data[5] !== pat_11 || rec_addr[5] !== 20'h00300) begin
            failures++; $display("FAIL write_read: first=%0d data=%h addr=%h expected 5/11../00300", first_hit(1'b0, 6), rec_data[5], rec_addr[5]);
        end
    endtask

    task automatic test_contention();
        rsn_i = 1'b1; @(posedge clk_i); #1; rsn_i = 1'b0;
        pulse(1'b1, 20'h00124, 1'b1, 20'h00308, 1'b0, 128'h0);
        observe(12);
        checks++;
        if (first_hit(1'b1, 12) !== 5 || hit_count(1'b1, 12) !== 1 || rec_data[5] !== pat_11) begin
            failures++; $display("FAIL contend_dc_first: first=%0d count=%0d data=%h expected 5/1/11..", first_hit(1'b1, 12), hit_count(1'b1, 12), rec_data[5]);
        end
        checks++;
        if (first_hit(1'b0, 12) !== 10 || hit_count(1'b0, 12) !== 1 || rec_data[10] !== pat_a5) begin
            failures++; $display("FAIL contend_ic_second: first=%0d count=%0d data=%h expected 10/1/a5..", first_hit(1'b0, 12), hit_count(1'b0, 12), rec_data[10]);
        end
        checks++;
        if ({rec_busy[6], rec_busy[9], rec_busy[11]} !== 3'b110) begin
            failures++; $display("FAIL contend_busy: got %b expected 110", {rec_busy[6], rec_busy[9], rec_busy[11]});
        end
        pulse(1'b1, 20'h00124, 1'b1, 20'h00308, 1'b0, 128'h0);
        observe(12);
        checks++;
        if (first_hit(1'b0, 12) !== 5 || first_hit(1'b1, 12) !== 10) begin
            failures++; $display("FAIL contend_rr: ic=%0d dc=%0d expected ic 5 dc 10", first_hit(1'b0, 12), first_hit(1'b1, 12));
        end
    endtask

    task automatic test_duplicate();
        pulse(1'b1, 20'h00124, 1'b0, 20'h0, 1'b0, 128'h0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_i); #1;
            ic_rqst_i = 1'b0;
            rec_ic[k] = ic_ready_o; rec_dc[k] = dc_ready_o; rec_busy[k] = busy_o;
            rec_data[k] = mem_data_o; rec_addr[k] = mem_addr_o;
            if (k == 2) begin
                ic_rqst_i = 1'b1; ic_addr_i = 20'h00300;
            end
        end
        checks++;
        if (hit_count(1'b0, 12) !== 1 || first_hit(1'b0, 12) !== 5 || rec_data[5] !== pat_a5) begin
            failures++; $display("FAIL duplicate: count=%0d first=%0d data=%h expected 1/5/a5..", hit_count(1'b0, 12), first_hit(1'b0, 12), rec_data[5]);
        end
        checks++;
        if (rec_busy[8] !== 1'b0) begin
            failures++; $display("FAIL duplicate_busy: got %b expected 0", rec_busy[8]);
        end
    endtask

    task automatic test_reset_mid_busy();
        write_line(20'h00400, pat_22);
        pulse(1'b0, 20'h0, 1'b1, 20'h00400, 1'b1, pat_dead);
        observe(2);
        rsn_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, ic_ready_o, dc_ready_o} !== 3'b000 || mem_data_o !== 128'h0 || mem_addr_o !== 20'h0) begin
            failures++; $display("FAIL reset_async: flags=%b data=%h addr=%h expected all zero", {busy_o, ic_ready_o, dc_ready_o}, mem_data_o, mem_addr_o);
        end
        @(posedge clk_i); #1;
        rsn_i = 1'b0;
        observe(6);
        checks++;
        if (hit_count(1'b1, 6) !== 0 || hit_count(1'b0, 6) !== 0) begin
            failures++; $display("FAIL reset_no_ready: dc=%0d ic=%0d expected 0/0", hit_count(1'b1, 6), hit_count(1'b0, 6));
        end
        pulse(1'b1, 20'h00400, 1'b0, 20'h0, 1'b0, 128'h0);
        observe(6);
        checks++;
        if (first_hit(1'b0, 6) !== 5 || rec_data[5] !== pat_22) begin
            failures++; $display("FAIL reset_line_kept: first=%0d data=%h expected 5/22..", first_hit(1'b0, 6), rec_data[5]);
        end
    endtask

    task automatic test_alias();
        pulse(1'b1, 20'hF0120, 1'b0, 20'h0, 1'b0, 128'h0);
        observe(6);
        checks++;
        if (first_hit(1'b0, 6) !== 5 || rec_data[5] !== pat_a5 || rec_addr[5] !== 20'hF0120) begin
            failures++; $display("FAIL alias: first=%0d data=%h addr=%h expected 5/a5../f0120", first_hit(1'b0, 6), rec_data[5], rec_addr[5]);
        end
    endtask

    initial begin
        pat_a5   = {16{8'hA5}};
        pat_11   = {16{8'h11}};
        pat_22   = {16{8'h22}};
        pat_dead = {4{32'hDEADBEEF}};
        test_reset();
        test_single_fill();
        test_write_read();
        test_contention();
        test_duplicate();
        test_reset_mid_busy();
        test_alias();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
